// File: rtl/mux_bus_pkg.sv
// Shared types and constants for the two-bank tristate mux bus arbiter.
// Bank 0 drives through the active-low-enable mux, bank 1 through the active-high one.
package mux_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    TURN  = 2'b10
  } state_t;

  localparam int BANK_BIT = 2;
  localparam int SEL_MSB  = 1;
  localparam int SEL_LSB  = 0;

  localparam logic EN_L_DRIVE = 1'b0;
  localparam logic EN_L_IDLE  = 1'b1;
  localparam logic EN_H_DRIVE = 1'b1;
  localparam logic EN_H_IDLE  = 1'b0;

  function automatic logic bank_of(input logic [2:0] idx);
    return idx[BANK_BIT];
  endfunction

endpackage

// File: rtl/mux_bus_arbiter_if.sv
// Request/acknowledge and mux-control bundle between the arbiter and the bus side.
interface mux_bus_arbiter_if;
  logic [7:0] req;
  logic       ack;
  logic [1:0] sel;
  logic       en_l;
  logic       en_h;
  logic       valid;
  logic [2:0] grant_idx;
  logic       done;
  logic       timeout;

  modport master (
    input  req, ack,
    output sel, en_l, en_h, valid, grant_idx, done, timeout
  );

  modport slave (
    output req, ack,
    input  sel, en_l, en_h, valid, grant_idx, done, timeout
  );
endinterface

// File: rtl/mux_bus_arbiter_rr_pick_8.sv
// Combinational round-robin picker: first set request at or after ptr, modulo 8.
module rr_pick_8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       any,
  output logic [2:0] idx
);
  logic [7:0] rot;
  logic [2:0] off;

  // rot[k] is the request that sits k places after ptr; 3-bit index wraps 7 -> 0.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign rot[gi] = req[ptr + 3'(gi)];
  end

  always_comb begin
    off = '0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
  end

  assign any = |req;
  assign idx = ptr + off;
endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter steering two 4:1 tristate muxes onto one shared bus wire,
// with a both-off turnaround cycle after every grant.
module mux_bus_arbiter
  import mux_bus_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  mux_bus_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_reg;
  logic [2:0]       ptr_reg;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic [2:0]       grant_idx_reg;
  logic [1:0]       sel_reg;
  logic             en_l_reg;
  logic             en_h_reg;
  logic             valid_reg;
  logic             done_reg;
  logic             timeout_reg;

  logic       pick_any;
  logic [2:0] pick_idx;

  rr_pick_8 u_pick (
    .req (bus.req),
    .ptr (ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      hold_cnt_reg  <= '0;
      grant_idx_reg <= '0;
      sel_reg       <= '0;
      en_l_reg      <= EN_L_IDLE;
      en_h_reg      <= EN_H_IDLE;
      valid_reg     <= 1'b0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg    <= 1'b0;
          timeout_reg <= 1'b0;
          if (pick_any) begin
            grant_idx_reg <= pick_idx;
            sel_reg       <= pick_idx[SEL_MSB:SEL_LSB];
            // Exactly one mux is enabled; the other stays high-Z.
            en_l_reg      <= bank_of(pick_idx) ? EN_L_IDLE  : EN_L_DRIVE;
            en_h_reg      <= bank_of(pick_idx) ? EN_H_DRIVE : EN_H_IDLE;
            valid_reg     <= 1'b1;
            hold_cnt_reg  <= '0;
            state_reg     <= DRIVE;
          end
        end
        DRIVE: begin
          hold_cnt_reg <= hold_cnt_reg + 1'b1;
          // ack takes priority over expiry when both land in the last cycle.
          if (bus.ack || (hold_cnt_reg == CNT_LAST)) begin
            done_reg    <= bus.ack;
            timeout_reg <= ~bus.ack;
            en_l_reg    <= EN_L_IDLE;
            en_h_reg    <= EN_H_IDLE;
            valid_reg   <= 1'b0;
            state_reg   <= TURN;
          end
        end
        TURN: begin
          done_reg    <= 1'b0;
          timeout_reg <= 1'b0;
          ptr_reg     <= grant_idx_reg + 3'd1;
          state_reg   <= IDLE;
        end
        default: begin
          en_l_reg  <= EN_L_IDLE;
          en_h_reg  <= EN_H_IDLE;
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.sel       = sel_reg;
  assign bus.en_l      = en_l_reg;
  assign bus.en_h      = en_h_reg;
  assign bus.valid     = valid_reg;
  assign bus.grant_idx = grant_idx_reg;
  assign bus.done      = done_reg;
  assign bus.timeout   = timeout_reg;
endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Directed plus randomized checks of mux_bus_arbiter against a transaction-level model.
module tb_mux_bus_arbiter;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  int   ptr_m = 0;

  mux_bus_arbiter_if bus ();

  mux_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner is the first requester found walking forward from the model pointer.
  function automatic int model_pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  // One grant: req held through IDLE, ack raised in DRIVE cycle ack_at
  // (ack_at > MAX_HOLD means never), optional junk on req while driving.
  task automatic do_grant(input logic [7:0] r, input int ack_at, input bit drop);
    int w;
    int n;
    int exp_len;
    logic [2:0] w3;
    bus.req = r;
    if (r == 8'h00) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("idle_valid", bus.valid, 0);
        chk("idle_en_h", bus.en_h, 0);
      end
      $display("txn req=%02h no grant", r);
      return;
    end
    w  = model_pick(r, ptr_m);
    w3 = 3'(w);
    @(negedge clk);
    chk("start_valid", bus.valid, 1);
    chk("grant_idx", bus.grant_idx, w);
    chk("sel", bus.sel, w3[1:0]);
    chk("en_l", bus.en_l, w3[2]);
    chk("en_h", bus.en_h, w3[2]);
    n = 0;
    while (bus.valid === 1'b1 && n <= MAX_HOLD + 1) begin
      n++;
      bus.ack = (n == ack_at);
      if (drop) bus.req = 8'($urandom);
      @(negedge clk);
    end
    exp_len = (ack_at <= MAX_HOLD) ? ack_at : MAX_HOLD;
    chk("drive_len", n, exp_len);
    chk("turn_done", bus.done, (ack_at <= MAX_HOLD) ? 1 : 0);
    chk("turn_timeout", bus.timeout, (ack_at <= MAX_HOLD) ? 0 : 1);
    chk("turn_en_l", bus.en_l, 1);
    chk("turn_en_h", bus.en_h, 0);
    bus.ack = 1'($urandom);
    @(negedge clk);
    chk("idle_pulse", {bus.done, bus.timeout, bus.valid}, 0);
    chk("hold_grant", bus.grant_idx, w);
    chk("hold_sel", bus.sel, w3[1:0]);
    bus.ack = 1'($urandom);
    ptr_m = (w + 1) % 8;
    $display("txn req=%02h grant=%0d len=%0d end=%s", r, w, n,
             (ack_at <= MAX_HOLD) ? "ack" : "timeout");
  endtask

  initial begin
    bus.req = 8'hFF;
    bus.ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en_l", bus.en_l, 1);
    chk("rst_en_h", bus.en_h, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_grant", bus.grant_idx, 0);
    chk("rst_pulses", {bus.done, bus.timeout}, 0);
    rst   = 1'b0;
    ptr_m = 0;

    // Full round of back-to-back ack-in-first-cycle grants, then wrap to 0.
    for (int i = 0; i < 9; i++) do_grant(8'hFF, 1, 0);

    // Requester 5 alone, never acked.
    do_grant(8'h20, MAX_HOLD + 1, 0);

    // Pointer now at 6: alternate between 6 and 0, with 6 dropping req.
    do_grant(8'h41, 2, 1);
    do_grant(8'h41, 1, 0);
    do_grant(8'h41, MAX_HOLD + 1, 1);
    do_grant(8'h41, 3, 0);

    // ack in the last allowed cycle wins over expiry.
    do_grant(8'h08, MAX_HOLD, 0);
    do_grant(8'h00, 1, 0);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_grant(r, $urandom_range(1, MAX_HOLD + 1), 1'($urandom));
    end

    // Reset mid-DRIVE on a bank-1 grant must float the bus before the next edge.
    bus.ack = 1'b0;
    bus.req = 8'h10;
    @(negedge clk);
    chk("pre_rst_en_h", bus.en_h, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_en_h", bus.en_h, 0);
    chk("async_en_l", bus.en_l, 1);
    chk("async_valid", bus.valid, 0);
    chk("async_grant", bus.grant_idx, 0);
    @(negedge clk);
    rst   = 1'b0;
    ptr_m = 0;
    do_grant(8'h81, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
